// File: rtl/mdu_if.sv
// Issue/read bundle between the CPU pipeline and the multiply/divide unit.
// The pipeline drives operations and the HI/LO select; the unit returns rdata and busy.
interface mdu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hilo_sel;
    logic [31:0] rdata;
    logic        busy;

    modport master (
        output start,
        output op,
        output a,
        output b,
        output hilo_sel,
        input  rdata,
        input  busy
    );

    modport slave (
        input  start,
        input  op,
        input  a,
        input  b,
        input  hilo_sel,
        output rdata,
        output busy
    );
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit holding architectural HI/LO. The result is computed at issue,
// parked in pending registers and committed after a fixed MULT/DIV latency.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] COUNT_ONE = CW'(1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [31:0]     hi_reg, hi_next;
    logic [31:0]     lo_reg, lo_next;
    logic [31:0]     pend_hi_reg, pend_hi_next;
    logic [31:0]     pend_lo_reg, pend_lo_next;
    logic            pend_valid_reg, pend_valid_next;

    // Even op codes of the arithmetic group are the signed variants.
    logic            is_signed;
    logic [63:0]     mul_a, mul_b, mul_prod;
    logic            a_neg, b_neg;
    logic [31:0]     a_mag, b_mag, div_den;
    logic [31:0]     q_mag, r_mag;
    logic [31:0]     quot, rem;
    logic            div_by_zero;

    assign is_signed = ~bus.op[0];

    // Sign/zero extension to 64 bits makes the low half of one product valid for both.
    assign mul_a    = {{32{is_signed & bus.a[31]}}, bus.a};
    assign mul_b    = {{32{is_signed & bus.b[31]}}, bus.b};
    assign mul_prod = mul_a * mul_b;

    // Divide on magnitudes, then restore signs: quotient truncates toward zero and
    // the remainder follows the dividend; 0x80000000 / -1 falls out as 0x80000000 r 0.
    assign a_neg       = is_signed & bus.a[31];
    assign b_neg       = is_signed & bus.b[31];
    assign a_mag       = a_neg ? (-bus.a) : bus.a;
    assign b_mag       = b_neg ? (-bus.b) : bus.b;
    assign div_by_zero = (bus.b == 32'd0);
    assign div_den     = div_by_zero ? 32'd1 : b_mag;
    assign q_mag       = a_mag / div_den;
    assign r_mag       = a_mag % div_den;
    assign quot        = (a_neg ^ b_neg) ? (-q_mag) : q_mag;
    assign rem         = a_neg ? (-r_mag) : r_mag;

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        hi_next         = hi_reg;
        lo_next         = lo_reg;
        pend_hi_next    = pend_hi_reg;
        pend_lo_next    = pend_lo_reg;
        pend_valid_next = pend_valid_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            pend_hi_next    = mul_prod[63:32];
                            pend_lo_next    = mul_prod[31:0];
                            pend_valid_next = 1'b1;
                            count_next      = MULT_LOAD;
                            state_next      = BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_next    = rem;
                            pend_lo_next    = quot;
                            pend_valid_next = ~div_by_zero;
                            count_next      = DIV_LOAD;
                            state_next      = BUSY;
                        end
                        OP_MTHI: hi_next = bus.a;
                        OP_MTLO: lo_next = bus.a;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                count_next = count_reg - COUNT_ONE;
                if (count_reg == COUNT_ONE) begin
                    if (pend_valid_reg) begin
                        hi_next = pend_hi_reg;
                        lo_next = pend_lo_reg;
                    end
                    pend_valid_next = 1'b0;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            hi_reg         <= '0;
            lo_reg         <= '0;
            pend_hi_reg    <= '0;
            pend_lo_reg    <= '0;
            pend_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            hi_reg         <= hi_next;
            lo_reg         <= lo_next;
            pend_hi_reg    <= pend_hi_next;
            pend_lo_reg    <= pend_lo_next;
            pend_valid_reg <= pend_valid_next;
        end
    end

    assign bus.busy  = (state_reg == BUSY);
    assign bus.rdata = bus.hilo_sel ? hi_reg : lo_reg;

endmodule
